// File: rtl/sipo_framer.sv
// Serial-in/parallel-out framer: collects WIDTH serial bits into a frame and
// hands each completed word to a consumer through a valid/ready register.
//
// state   | meaning
// COLLECT | bit_cnt < WIDTH-1, still gathering frame bits
// LAST    | bit_cnt = WIDTH-1, next enabled bit completes the frame
module sipo_framer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     si,
   input  logic                     clr,
   output logic [WIDTH-1:0]         sr,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid,
   input  logic                     q_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_PRELAST = CW'(WIDTH - 2);

   typedef enum logic {COLLECT = 1'b0, LAST = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_ovf;
   logic [WIDTH-1:0] w_shift;
   logic             w_complete;
   logic             w_in_last;

   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shift = {r_sr[WIDTH-2:0], si};
      end else begin : g_lsb
         assign w_shift = {si, r_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) r_state <= COLLECT;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = COLLECT;
      end else if (en) begin
         case (r_state)
            COLLECT: if (r_bit_cnt == CNT_PRELAST) w_state_nxt = LAST;
            LAST:    w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
         endcase
      end
   end

   always_comb begin
      w_in_last  = (r_state == LAST);
      w_complete = w_in_last && en && !clr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (clr) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
         end else if (en) begin
            r_sr      <= w_shift;
            r_bit_cnt <= w_in_last ? '0 : r_bit_cnt + CW'(1);
         end
         // A completing word only displaces q when the old word is gone or leaving now.
         if (w_complete) begin
            if (!r_q_valid || q_ready) begin
               r_q       <= w_shift;
               r_q_valid <= 1'b1;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_q_valid && q_ready) begin
            r_q_valid <= 1'b0;
         end
      end
   end

   assign sr      = r_sr;
   assign q       = r_q;
   assign q_valid = r_q_valid;
   assign bit_cnt = r_bit_cnt;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_sipo_framer.sv
// Bench for sipo_framer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a frame-level reference model.
module tb_sipo_framer;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0, en = 1'b0, si = 1'b0, clr = 1'b0, q_ready = 1'b0;
   logic [W-1:0] sr_m, q_m, sr_l, q_l;
   logic         qv_m, qv_l, ovf_m, ovf_l;
   logic [1:0]   cnt_m, cnt_l;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .en(en), .si(si), .clr(clr),
      .sr(sr_m), .q(q_m), .q_valid(qv_m), .q_ready(q_ready),
      .bit_cnt(cnt_m), .ovf(ovf_m));

   sipo_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .en(en), .si(si), .clr(clr),
      .sr(sr_l), .q(q_l), .q_valid(qv_l), .q_ready(q_ready),
      .bit_cnt(cnt_l), .ovf(ovf_l));

   // reference model: bits of the open frame, bit history since last clear
   int           frame[$];
   int           hist[$];
   logic [W-1:0] mq_m, mq_l;
   logic         mv, movf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] sr_from_hist(input bit msb);
      logic [W-1:0] v = '0;
      for (int i = 0; i < W; i++)
         if (hist.size() > i) begin
            if (msb) v[i] = hist[hist.size()-1-i][0];
            else     v[W-1-i] = hist[hist.size()-1-i][0];
         end
      return v;
   endfunction

   task automatic model_step(input logic r, e, s, c, y);
      logic         complete;
      logic [W-1:0] wm, wl;
      if (!r) begin
         frame.delete(); hist.delete();
         mq_m = '0; mq_l = '0; mv = 1'b0; movf = 1'b0;
         return;
      end
      complete = e && !c && (frame.size() == W-1);
      wm = '0; wl = '0;
      if (complete) begin
         frame.push_back(int'(s));
         for (int i = 0; i < W; i++) begin
            wm[W-1-i] = frame[i][0];
            wl[i]     = frame[i][0];
         end
         frame.delete();
         if (!mv || y) begin
            mq_m = wm; mq_l = wl; mv = 1'b1;
         end else begin
            movf = 1'b1;
         end
      end else if (mv && y) begin
         mv = 1'b0;
      end
      if (c) begin
         frame.delete(); hist.delete(); movf = 1'b0;
      end else if (e) begin
         if (!complete) frame.push_back(int'(s));
         hist.push_back(int'(s));
         if (hist.size() > W) void'(hist.pop_front());
      end
   endtask

   task automatic check_model();
      chk("sr_msb",  {28'd0, sr_m}, {28'd0, sr_from_hist(1'b1)});
      chk("sr_lsb",  {28'd0, sr_l}, {28'd0, sr_from_hist(1'b0)});
      chk("q_msb",   {28'd0, q_m},  {28'd0, mq_m});
      chk("q_lsb",   {28'd0, q_l},  {28'd0, mq_l});
      chk("qv_msb",  {31'd0, qv_m}, {31'd0, mv});
      chk("qv_lsb",  {31'd0, qv_l}, {31'd0, mv});
      chk("cnt_msb", {30'd0, cnt_m}, 32'(frame.size()));
      chk("cnt_lsb", {30'd0, cnt_l}, 32'(frame.size()));
      chk("ovf_msb", {31'd0, ovf_m}, {31'd0, movf});
      chk("ovf_lsb", {31'd0, ovf_l}, {31'd0, movf});
   endtask

   task automatic cycle(input logic r, e, s, c, y);
      rst = r; en = e; si = s; clr = c; q_ready = y;
      @(posedge clk);
      model_step(r, e, s, c, y);
      #1;
      check_model();
   endtask

   task automatic frame4(input logic [3:0] bits, input logic y_last);
      for (int i = 3; i >= 0; i--) cycle(1'b1, 1'b1, bits[i], 1'b0, (i == 0) ? y_last : 1'b0);
   endtask

   typedef struct {
      logic       rst, en, si, clr, rdy;
      logic [3:0] m_sr, m_q;
      logic       qv;
      logic [1:0] cnt;
      logic       ovf;
      logic [3:0] l_q;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,4'b0000,1'b0,2'd0,1'b0,4'b0000};
      tbl[1] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4'b0001,4'b0000,1'b0,2'd1,1'b0,4'b0000};
      tbl[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4'b0011,4'b0000,1'b0,2'd2,1'b0,4'b0000};
      tbl[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0110,4'b0000,1'b0,2'd3,1'b0,4'b0000};
      tbl[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b1100,4'b1100,1'b1,2'd0,1'b0,4'b0011};
      tbl[5] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4'b1001,4'b1100,1'b1,2'd1,1'b0,4'b0011};
      tbl[6] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0010,4'b1100,1'b1,2'd2,1'b0,4'b0011};
      tbl[7] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4'b0101,4'b1100,1'b1,2'd3,1'b0,4'b0011};
      tbl[8] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b1010,4'b1100,1'b1,2'd0,1'b1,4'b0011};
      tbl[9] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 4'b1010,4'b1100,1'b0,2'd0,1'b1,4'b0011};

      // frame capture both bit orders, then overrun and late consume
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].rst, tbl[i].en, tbl[i].si, tbl[i].clr, tbl[i].rdy);
         chk($sformatf("tbl%0d_sr", i),  {28'd0, sr_m},  {28'd0, tbl[i].m_sr});
         chk($sformatf("tbl%0d_q", i),   {28'd0, q_m},   {28'd0, tbl[i].m_q});
         chk($sformatf("tbl%0d_qv", i),  {31'd0, qv_m},  {31'd0, tbl[i].qv});
         chk($sformatf("tbl%0d_cnt", i), {30'd0, cnt_m}, {30'd0, tbl[i].cnt});
         chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf_m}, {31'd0, tbl[i].ovf});
         chk($sformatf("tbl%0d_lq", i),  {28'd0, q_l},   {28'd0, tbl[i].l_q});
      end

      // gapped enable: bits 1,0,1,1 on enabled cycles only
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
         logic [3:0] b = 4'b1011;
         for (int i = 3; i >= 0; i--) begin
            cycle(1'b1, 1'b1, b[i], 1'b0, 1'b0);
            if (i != 0) begin
               chk("gap_no_early_valid", {31'd0, qv_m}, 32'd0);
               cycle(1'b1, 1'b0, ~b[i], 1'b0, 1'b0);
               chk("gap_cnt_hold", {30'd0, cnt_m}, 32'(4 - i));
            end
         end
      end
      chk("gap_q", {28'd0, q_m}, 32'hB);
      chk("gap_qv", {31'd0, qv_m}, 32'd1);

      // back-to-back: consume on the completing edge of the next frame
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      frame4(4'b1100, 1'b0);
      frame4(4'b0110, 1'b1);
      chk("b2b_q", {28'd0, q_m}, 32'h6);
      chk("b2b_qv", {31'd0, qv_m}, 32'd1);
      chk("b2b_ovf", {31'd0, ovf_m}, 32'd0);

      // reset mid-frame, then clr mid-frame with a handshake on the clr edge
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_cnt", {30'd0, cnt_m}, 32'd0);
      frame4(4'b1001, 1'b0);
      chk("rst_q", {28'd0, q_m}, 32'h9);
      frame4(4'b0101, 1'b0);
      chk("ovf_set", {31'd0, ovf_m}, 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_ovf", {31'd0, ovf_m}, 32'd0);
      chk("clr_qv", {31'd0, qv_m}, 32'd0);
      chk("clr_q", {28'd0, q_m}, 32'h9);
      chk("clr_sr", {28'd0, sr_m}, 32'd0);
      frame4(4'b1111, 1'b0);
      chk("clr_then_q", {28'd0, q_m}, 32'hF);
      chk("clr_then_ovf", {31'd0, ovf_m}, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++)
         cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
               1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
